// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer for a single-port 16x16 register file with a 1-cycle registered read.
// Serialises one or two source reads, presents operands via valid/ready and arbitrates writebacks.
module operand_fetch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_src_a,
  input  logic [ADDR_WIDTH-1:0] req_src_b,
  input  logic                  req_two_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_id,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_rd,
  output logic                  rf_wn,
  output logic [ADDR_WIDTH-1:0] rf_reg_id,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic [DATA_WIDTH-1:0] rf_read_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_CAP_A = 3'd3,
    S_CAP_B = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] r_src_a;
  logic [ADDR_WIDTH-1:0] r_src_b;
  logic                  r_two_op;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;

  assign op_a = r_op_a;
  assign op_b = r_op_b;

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    req_ready     = 1'b0;
    wb_ready      = 1'b0;
    out_valid     = 1'b0;
    rf_rd         = 1'b0;
    rf_wn         = 1'b0;
    rf_reg_id     = '0;
    rf_write_data = '0;
    unique case (r_state)
      S_IDLE: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          rf_wn         = 1'b1;
          rf_reg_id     = wb_id;
          rf_write_data = wb_data;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            w_accept = 1'b1;
            w_next   = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        rf_rd     = 1'b1;
        rf_reg_id = r_src_a;
        w_next    = r_two_op ? S_RD_B : S_CAP_A;
      end
      S_RD_B: begin
        rf_rd     = 1'b1;
        rf_reg_id = r_src_b;
        w_next    = S_CAP_B;
      end
      S_CAP_A: w_next = S_OUT;
      S_CAP_B: w_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset cycle: no strobes or handshakes toward either side of the port.
    if (rst) begin
      w_accept      = 1'b0;
      req_ready     = 1'b0;
      wb_ready      = 1'b0;
      out_valid     = 1'b0;
      rf_rd         = 1'b0;
      rf_wn         = 1'b0;
      rf_reg_id     = '0;
      rf_write_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_src_a  <= '0;
      r_src_b  <= '0;
      r_two_op <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src_a  <= req_src_a;
        r_src_b  <= req_src_b;
        r_two_op <= req_two_op;
      end
      // read_data lags the rd strobe by one edge, so each capture trails its read state.
      unique case (r_state)
        S_RD_B: r_op_a <= rf_read_data;
        S_CAP_A: begin
          r_op_a <= rf_read_data;
          r_op_b <= '0;
        end
        S_CAP_B: r_op_b <= rf_read_data;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/operand_fetch_ctrl.md
Name: operand_fetch_ctrl

Overview:
- Sequencer that sits directly upstream of the single-port 16x16 register file. It is the only master of the file's `rd`/`wn`/`reg_id`/`write_data` pins and consumes its `read_data`.
- Accepts operand-fetch requests (one or two source registers) and serialises the reads through the one port, accounting for the file's 1-cycle registered read.
- Presents captured operands downstream via valid/ready.
- Also arbitrates writeback requests into the same port.

Parameters:
- DATA_WIDTH, 16, register data width (matches register file).
- ADDR_WIDTH, 4, register index width (16 registers).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  fetch request valid
- req_ready  output  1  fetch request accepted when high with req_valid
- req_src_a  input  ADDR_WIDTH  first source register index
- req_src_b  input  ADDR_WIDTH  second source register index
- req_two_op  input  1  1 = fetch both sources, 0 = src_a only
- out_valid  output  1  operands valid
- out_ready  input  1  downstream accepts operands
- op_a  output  DATA_WIDTH  operand A
- op_b  output  DATA_WIDTH  operand B (0 when req_two_op=0)
- wb_valid  input  1  writeback request
- wb_ready  output  1  writeback accepted this cycle
- wb_id  input  ADDR_WIDTH  writeback register index
- wb_data  input  DATA_WIDTH  writeback data
- rf_rd  output  1  to register file rd
- rf_wn  output  1  to register file wn
- rf_reg_id  output  ADDR_WIDTH  to register file reg_id
- rf_write_data  output  DATA_WIDTH  to register file write_data
- rf_read_data  input  DATA_WIDTH  from register file read_data (updated at the edge where rf_rd=1)

Behaviour:
- Reset (`rst`=1 at an edge, any state, including mid-fetch):
  - state to IDLE; op_a, op_b, and latched src/two_op fields to 0; out_valid 0.
  - During the reset cycle, rf_rd=0 and rf_wn=0.
  - An in-flight request is dropped; no partial output.
- rf control outputs are combinational from state. rf_rd and rf_wn are never both 1. rf_reg_id = 0 and rf_write_data = 0 when both strobes are 0.
- State IDLE:
  - wb_ready=1.
  - If wb_valid: rf_wn=1, rf_reg_id=wb_id, rf_write_data=wb_data; req_ready=0; stay IDLE. Writeback has priority over fetch.
  - Else: req_ready=1. On req_valid, latch src_a, src_b, two_op and go to RD_A.
- State RD_A: rf_rd=1, rf_reg_id=src_a.
  - If two_op: go to RD_B; else go to CAP_A.
- State RD_B: rf_rd=1, rf_reg_id=src_b; capture op_a <= rf_read_data; go to CAP_B.
- State CAP_A: op_a <= rf_read_data, op_b <= 0; go to OUT.
- State CAP_B: op_b <= rf_read_data; go to OUT.
- State OUT:
  - out_valid=1; op_a/op_b held stable.
  - On out_ready: go to IDLE (out_valid low next cycle). Else hold.
- In every state other than IDLE: req_ready=0 and wb_ready=0. Writebacks stall until IDLE.
- Latency, with the request handshake at edge N:
  - two_op=1: out_valid is high after edge N+3.
  - two_op=0: out_valid is high after edge N+2.
  - Minimum request-to-request spacing: 5 cycles (two-op), 4 cycles (one-op).
- Back-to-back: OUT→IDLE takes one cycle. No request accepted in the OUT cycle.
- src_a == src_b: two reads issued; both operands equal.
- Hazard ordering: a writeback completed in IDLE before the request is accepted is visible to that request's reads.
- req_valid and wb_valid together in IDLE: writeback wins, request waits (req_ready=0).
- Signals are sampled only at handshake; input changes while busy are ignored.

Test Plan:
- Reset mid-fetch: issue two-op request, assert rst in RD_B → out_valid=0, op_a=op_b=0, state IDLE, rf_rd=0 next cycle; then a new request completes normally.
- Writeback then fetch: wb R3=0xBEEF, R7=0x1234; then request src_a=3, src_b=7, two_op=1 → out_valid after edge N+3, op_a=0xBEEF, op_b=0x1234; rf_rd pulses exactly 2 cycles, reg_id 3 then 7.
- Single-operand: R5=0x00A5, request src_a=5, two_op=0 → out_valid after edge N+2, op_a=0x00A5, op_b=0; rf_rd high exactly 1 cycle.
- Simultaneous wb_valid (R2=0x5555) and req_valid (src_a=2, src_b=2) in IDLE → write first (req_ready=0), request accepted next cycle; op_a=op_b=0x5555.
- Backpressure: hold out_ready=0 for 6 cycles in OUT → out_valid, op_a, op_b stable; wb_ready=0, req_ready=0, no rf strobes throughout; release → IDLE next cycle.
- Boundary index: write R15=0xFFFF and R0=0x0001, fetch src_a=15, src_b=0 → op_a=0xFFFF, op_b=0x0001.
